// File: rtl/console_pkg.sv
// Shared definitions for the console write controller: control codes, FSM states, default widths.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Optional feature macro: CONSOLE_FF_CLEAR_EN (adds the CLEAR state).
package console_pkg;

    localparam int CONSOLE_ADDR_W = 16;

    localparam logic [7:0] CHR_BS  = 8'h08;
    localparam logic [7:0] CHR_TAB = 8'h09;
    localparam logic [7:0] CHR_LF  = 8'h0A;
    localparam logic [7:0] CHR_FF  = 8'h0C;
    localparam logic [7:0] CHR_CR  = 8'h0D;

`ifdef CONSOLE_FF_CLEAR_EN
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;
`else
    typedef enum logic [0:0] {
        ST_RUN = 1'b0
    } state_t;
`endif

endpackage

// File: rtl/console_write_ctrl_if.sv
// Byte-stream input and RAM port-B write bundle for the console write controller.
// Latency: n/a (wiring only).
// Backpressure: data_ready from the controller throttles data_valid from the producer.
// Ports: data/data_valid/data_ready (stream), ram_ena/ram_wena/ram_addr/ram_wdata (RAM port B).
interface console_write_ctrl_if #(
    parameter int ADDR_W = console_pkg::CONSOLE_ADDR_W
);
    logic [7:0]        data;
    logic              data_valid;
    logic              data_ready;
    logic              ram_ena;
    logic              ram_wena;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;

    // Controller side: consumes bytes, drives the RAM port.
    modport slave (
        input  data, data_valid,
        output data_ready, ram_ena, ram_wena, ram_addr, ram_wdata
    );

    // Producer / RAM side.
    modport master (
        output data, data_valid,
        input  data_ready, ram_ena, ram_wena, ram_addr, ram_wdata
    );
endinterface

// File: rtl/console_write_ctrl_cursor.sv
// Next-cursor decode for one byte: printable advance with wrap, CR/LF/BS/TAB moves, FF untouched.
// Latency: combinational.
// Backpressure: none; caller applies the result only on a transfer.
// Ports: row_i/col_i (already inside the limits), chr_i, rows_i/cols_i (effective limits, >=1),
//        row_o/col_o next cursor, printable_o set when the byte must be written to RAM.
module console_cursor
    import console_pkg::*;
#(
    parameter int TAB_STOP = 8
) (
    input  logic [7:0] row_i,
    input  logic [7:0] col_i,
    input  logic [7:0] chr_i,
    input  logic [7:0] rows_i,
    input  logic [7:0] cols_i,
    output logic [7:0] row_o,
    output logic [7:0] col_o,
    output logic       printable_o
);

    // TAB_STOP is a power of two, so rounding down is a mask and the next stop is one step on.
    localparam logic [8:0] TAB_STEP = 9'(TAB_STOP);
    localparam logic [8:0] TAB_MASK = ~(TAB_STEP - 9'd1);

    logic [7:0] row_inc;
    logic [8:0] tab_col;

    always_comb begin
        row_inc     = (row_i == rows_i - 8'd1) ? 8'd0 : row_i + 8'd1;
        // Computed one bit wider so a stop past column 255 still compares as out of range.
        tab_col     = ({1'b0, col_i} & TAB_MASK) + TAB_STEP;
        row_o       = row_i;
        col_o       = col_i;
        printable_o = 1'b0;
        case (chr_i)
            CHR_CR: col_o = 8'd0;
            CHR_LF: begin
                row_o = row_inc;
                col_o = 8'd0;
            end
            CHR_BS: begin
                if (col_i != 8'd0) col_o = col_i - 8'd1;
            end
            CHR_TAB: begin
                if (tab_col >= {1'b0, cols_i}) begin
                    row_o = row_inc;
                    col_o = 8'd0;
                end else begin
                    col_o = tab_col[7:0];
                end
            end
            CHR_FF: begin
                // Screen clear is handled by the top level; the cursor decode leaves it alone.
            end
            default: begin
                printable_o = 1'b1;
                if (col_i == cols_i - 8'd1) begin
                    col_o = 8'd0;
                    row_o = row_inc;
                end else begin
                    col_o = col_i + 8'd1;
                end
            end
        endcase
    end

endmodule

// File: rtl/console_write_ctrl.sv
// Console write controller: byte stream in, one RAM write per printable byte at row*C+col.
// Latency: one cycle from transfer to RAM strobe and cursor update; full-rate back-to-back.
// Backpressure: data_ready is always high except during a screen clear (CONSOLE_FF_CLEAR_EN).
// Ports: CLK_DATA, reset_n (async active-low), max_rows/max_columns (0 means 1), bus (slave:
//        stream + RAM port B), cursor_row/cursor_col, busy (high while clearing).
module console_write_ctrl
    import console_pkg::*;
#(
    parameter int         ADDR_W     = CONSOLE_ADDR_W,
    parameter int         TAB_STOP   = 8,
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic                 CLK_DATA,
    input  logic                 reset_n,
    input  logic [7:0]           max_rows,
    input  logic [7:0]           max_columns,
    console_write_ctrl_if.slave  bus,
    output logic [7:0]           cursor_row,
    output logic [7:0]           cursor_col,
    output logic                 busy
);

    logic [7:0]        row_q, row_d, col_q, col_d;
    logic              ram_ena_q, ram_ena_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_wdata_q, ram_wdata_d;

    logic [7:0]  rows_eff, cols_eff, row_in, col_in;
    logic [7:0]  nxt_row, nxt_col;
    logic        is_printable;
    logic        data_ready;
    logic        xfer;
    logic [15:0] lin_addr;

`ifdef CONSOLE_FF_CLEAR_EN
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;      // index of the blank write currently on the RAM port
    logic [15:0] total_q, total_d;  // R*C latched when the clear starts
`endif

    // Limits of zero behave as one; an out-of-range coordinate (limits shrank) restarts at 0.
    assign rows_eff = (max_rows    == 8'd0) ? 8'd1 : max_rows;
    assign cols_eff = (max_columns == 8'd0) ? 8'd1 : max_columns;
    assign row_in   = (row_q >= rows_eff) ? 8'd0 : row_q;
    assign col_in   = (col_q >= cols_eff) ? 8'd0 : col_q;
    assign lin_addr = ({8'd0, row_in} * {8'd0, cols_eff}) + {8'd0, col_in};

`ifdef CONSOLE_FF_CLEAR_EN
    assign data_ready = (state_q != ST_CLEAR);
    assign busy       = (state_q == ST_CLEAR);
`else
    assign data_ready = 1'b1;
    assign busy       = 1'b0;
    logic unused_blank;
    assign unused_blank = ^BLANK_CHAR;
`endif

    assign xfer = bus.data_valid && data_ready;

    console_cursor #(
        .TAB_STOP(TAB_STOP)
    ) u_cursor (
        .row_i      (row_in),
        .col_i      (col_in),
        .chr_i      (bus.data),
        .rows_i     (rows_eff),
        .cols_i     (cols_eff),
        .row_o      (nxt_row),
        .col_o      (nxt_col),
        .printable_o(is_printable)
    );

    always_comb begin
        row_d       = row_q;
        col_d       = col_q;
        ram_ena_d   = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
`ifdef CONSOLE_FF_CLEAR_EN
        state_d     = state_q;
        cnt_d       = cnt_q;
        total_d     = total_q;
        if (state_q == ST_CLEAR) begin
            if (cnt_q == total_q - 16'd1) begin
                // Last blank is on the port this cycle; resume with the cursor home.
                state_d = ST_RUN;
                row_d   = 8'd0;
                col_d   = 8'd0;
            end else begin
                cnt_d       = cnt_q + 16'd1;
                ram_ena_d   = 1'b1;
                ram_addr_d  = ADDR_W'(cnt_q + 16'd1);
                ram_wdata_d = BLANK_CHAR;
            end
        end else if (xfer && (bus.data == CHR_FF)) begin
            // The first blank (address 0) is issued with the entry itself, so the clear
            // occupies exactly R*C cycles of write strobes.
            state_d     = ST_CLEAR;
            cnt_d       = 16'd0;
            total_d     = {8'd0, rows_eff} * {8'd0, cols_eff};
            ram_ena_d   = 1'b1;
            ram_addr_d  = '0;
            ram_wdata_d = BLANK_CHAR;
        end else
`endif
        if (xfer) begin
            row_d = nxt_row;
            col_d = nxt_col;
            if (is_printable) begin
                ram_ena_d   = 1'b1;
                ram_addr_d  = ADDR_W'(lin_addr);
                ram_wdata_d = bus.data;
            end
        end
    end

    always_ff @(posedge CLK_DATA or negedge reset_n) begin
        if (!reset_n) begin
            row_q       <= 8'd0;
            col_q       <= 8'd0;
            ram_ena_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= 8'd0;
`ifdef CONSOLE_FF_CLEAR_EN
            state_q     <= ST_RUN;
            cnt_q       <= 16'd0;
            total_q     <= 16'd0;
`endif
        end else begin
            row_q       <= row_d;
            col_q       <= col_d;
            ram_ena_q   <= ram_ena_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
`ifdef CONSOLE_FF_CLEAR_EN
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            total_q     <= total_d;
`endif
        end
    end

    assign bus.data_ready = data_ready;
    assign bus.ram_ena    = ram_ena_q;
    assign bus.ram_wena   = ram_ena_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_wdata  = ram_wdata_q;
    assign cursor_row     = row_q;
    assign cursor_col     = col_q;

endmodule
